// File: rtl/input_mapper_pkg.sv
// rtl/input_mapper_pkg.sv - keymap table and control-vector layout for input_mapper
package input_mapper_pkg;

   // What a keyboard key drives inside a player's control vector
   typedef enum logic [3:0] {
      ROLE_RIGHT,
      ROLE_LEFT,
      ROLE_DOWN,
      ROLE_UP,
      ROLE_BUTTON,
      ROLE_START,
      ROLE_COIN,
      ROLE_PAUSE,
      ROLE_SERVICE
   } key_role_e;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic [1:0] player;
      key_role_e  role;
      logic [2:0] button;
   } keymap_entry_t;

   localparam int KEYMAP_SIZE = 21;

   localparam int IDX_RIGHT = 0;
   localparam int IDX_LEFT  = 1;
   localparam int IDX_DOWN  = 2;
   localparam int IDX_UP    = 3;
   localparam int IDX_BTN0  = 4;
   localparam int IDX_NONE  = -1;

   function automatic int ctrl_width(input int buttons);
      return buttons + 7;
   endfunction

   function automatic int idx_start(input int buttons);
      return buttons + 4;
   endfunction

   function automatic int idx_coin(input int buttons);
      return buttons + 5;
   endfunction

   function automatic int idx_pause(input int buttons);
      return buttons + 6;
   endfunction

   function automatic keymap_entry_t make_entry(input logic [7:0] code, input logic ext,
                                                input logic [1:0] player, input key_role_e role,
                                                input logic [2:0] button);
      keymap_entry_t e;
      e.code   = code;
      e.ext    = ext;
      e.player = player;
      e.role   = role;
      e.button = button;
      return e;
   endfunction

   // Fixed keymap; players 3/4 and buttons above 3 have no keys
   function automatic keymap_entry_t keymap_entry(input int i);
      case (i)
         0:       return make_entry(8'h75, 1'b1, 2'd0, ROLE_UP,      3'd0);
         1:       return make_entry(8'h72, 1'b1, 2'd0, ROLE_DOWN,    3'd0);
         2:       return make_entry(8'h6B, 1'b1, 2'd0, ROLE_LEFT,    3'd0);
         3:       return make_entry(8'h74, 1'b1, 2'd0, ROLE_RIGHT,   3'd0);
         4:       return make_entry(8'h14, 1'b0, 2'd0, ROLE_BUTTON,  3'd0);
         5:       return make_entry(8'h11, 1'b0, 2'd0, ROLE_BUTTON,  3'd1);
         6:       return make_entry(8'h29, 1'b0, 2'd0, ROLE_BUTTON,  3'd2);
         7:       return make_entry(8'h16, 1'b0, 2'd0, ROLE_START,   3'd0);
         8:       return make_entry(8'h2E, 1'b0, 2'd0, ROLE_COIN,    3'd0);
         9:       return make_entry(8'h4D, 1'b0, 2'd0, ROLE_PAUSE,   3'd0);
         10:      return make_entry(8'h46, 1'b0, 2'd0, ROLE_SERVICE, 3'd0);
         11:      return make_entry(8'h2D, 1'b0, 2'd1, ROLE_UP,      3'd0);
         12:      return make_entry(8'h2B, 1'b0, 2'd1, ROLE_DOWN,    3'd0);
         13:      return make_entry(8'h23, 1'b0, 2'd1, ROLE_LEFT,    3'd0);
         14:      return make_entry(8'h34, 1'b0, 2'd1, ROLE_RIGHT,   3'd0);
         15:      return make_entry(8'h1C, 1'b0, 2'd1, ROLE_BUTTON,  3'd0);
         16:      return make_entry(8'h1B, 1'b0, 2'd1, ROLE_BUTTON,  3'd1);
         17:      return make_entry(8'h15, 1'b0, 2'd1, ROLE_BUTTON,  3'd2);
         18:      return make_entry(8'h1E, 1'b0, 2'd1, ROLE_START,   3'd0);
         19:      return make_entry(8'h36, 1'b0, 2'd1, ROLE_COIN,    3'd0);
         default: return make_entry(8'h45, 1'b0, 2'd1, ROLE_SERVICE, 3'd0);
      endcase
   endfunction

   // Bit position of a key inside its player's vector; service sits outside it
   function automatic int role_bit(input keymap_entry_t e, input int buttons);
      case (e.role)
         ROLE_RIGHT:  return IDX_RIGHT;
         ROLE_LEFT:   return IDX_LEFT;
         ROLE_DOWN:   return IDX_DOWN;
         ROLE_UP:     return IDX_UP;
         ROLE_BUTTON: return (int'(e.button) < buttons) ? IDX_BTN0 + int'(e.button) : IDX_NONE;
         ROLE_START:  return idx_start(buttons);
         ROLE_COIN:   return idx_coin(buttons);
         ROLE_PAUSE:  return idx_pause(buttons);
         default:     return IDX_NONE;
      endcase
   endfunction

endpackage

// File: rtl/input_mapper_pulse_stretch.sv
// rtl/input_mapper_pulse_stretch.sv - stretches each rising edge of a level to HOLD clocks
module pulse_stretch
#(
   parameter int HOLD = 1_000_000
)
(
   input  logic clock,
   input  logic reset_n,
   input  logic i_level,
   output logic o_active
);

   localparam int CNT_W = 20;

   logic             r_level_d;
   logic [CNT_W-1:0] r_cnt;
   logic             w_rise;

   // Active on the edge cycle itself, then for HOLD-1 further cycles
   always_comb begin
      w_rise   = i_level & ~r_level_d;
      o_active = w_rise | (r_cnt != '0);
   end

   // Edge detect and remaining-hold counter; a new edge reloads the counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_level_d <= i_level;
         if (w_rise) begin
            r_cnt <= CNT_W'(HOLD - 1);
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/input_mapper.sv
// rtl/input_mapper.sv - merges keyboard keys and gamepads into per-player control vectors
module input_mapper
   import input_mapper_pkg::*;
#(
   parameter int PLAYERS   = 2,
   parameter int BUTTONS   = 3,
   parameter int COIN_HOLD = 1_000_000
)
(
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic [10:0]                      ps2_key,
   input  logic                             kbd_clear,
   input  logic [PLAYERS*(BUTTONS+7)-1:0]   joystick,
   input  logic                             vblank,
   input  logic [PLAYERS*BUTTONS-1:0]       autofire_mask,
   input  logic [7:0]                       autofire_period,
   output logic [PLAYERS*(BUTTONS+7)-1:0]   controls,
   output logic [PLAYERS-1:0]               service
);

   localparam int CTRL_W   = ctrl_width(BUTTONS);
   localparam int NCTRL    = PLAYERS * CTRL_W;
   localparam int COIN_BIT = idx_coin(BUTTONS);

   function automatic logic [NCTRL-1:0] entry_ctrl_mask(input int i);
      keymap_entry_t    e;
      logic [NCTRL-1:0] m;
      int               b;
      e = keymap_entry(i);
      b = role_bit(e, BUTTONS);
      m = '0;
      if ((int'(e.player) < PLAYERS) && (b != IDX_NONE)) begin
         m[int'(e.player) * CTRL_W + b] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [PLAYERS-1:0] entry_svc_mask(input int i);
      keymap_entry_t      e;
      logic [PLAYERS-1:0] m;
      e = keymap_entry(i);
      m = '0;
      if ((e.role == ROLE_SERVICE) && (int'(e.player) < PLAYERS)) begin
         m[int'(e.player)] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic entry_matches(input int i, input logic [8:0] key);
      keymap_entry_t e;
      e = keymap_entry(i);
      return ({e.ext, e.code} == key);
   endfunction

   logic                   r_armed;
   logic                   r_prev_toggle;
   logic [KEYMAP_SIZE-1:0] r_held;
   logic [NCTRL-1:0]       r_joy;
   logic                   r_vblank_d;
   logic [7:0]             r_period_d;
   logic [7:0]             r_af_cnt;
   logic                   r_af_phase;
   logic                   r_af_restart;
   logic [NCTRL-1:0]       r_controls;
   logic [PLAYERS-1:0]     r_service;

   logic                   w_event;
   logic [KEYMAP_SIZE-1:0] w_match;
   logic [NCTRL-1:0]       w_key_ctrl;
   logic [PLAYERS-1:0]     w_key_svc;
   logic [NCTRL-1:0]       w_raw;
   logic [PLAYERS-1:0]     w_coin_active;
   logic                   w_vb_rise;
   logic                   w_period_changed;
   logic                   w_af_on;
   logic [7:0]             w_cnt_base;
   logic [NCTRL-1:0]       w_next_ctrl;

   // Toggle edge detect; the first sample after reset only primes the history
   always_comb begin
      w_event = r_armed && (ps2_key[10] != r_prev_toggle);
      for (int i = 0; i < KEYMAP_SIZE; i++) begin
         w_match[i] = entry_matches(i, ps2_key[8:0]);
      end
   end

   // Toggle history and the arm flag that suppresses the post-reset event
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_armed       <= 1'b0;
         r_prev_toggle <= 1'b0;
      end else begin
         r_armed       <= 1'b1;
         r_prev_toggle <= ps2_key[10];
      end
   end

   // Held key states; a clear in the same cycle discards the event
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_held <= '0;
      end else if (kbd_clear) begin
         r_held <= '0;
      end else if (w_event) begin
         for (int i = 0; i < KEYMAP_SIZE; i++) begin
            if (w_match[i]) begin
               r_held[i] <= ps2_key[9];
            end
         end
      end
   end

   // Gamepad inputs are registered once so both sources see the same latency
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_joy <= '0;
      end else begin
         r_joy <= joystick;
      end
   end

   // Project held keys onto control-vector and service bits, then merge
   always_comb begin
      w_key_ctrl = '0;
      w_key_svc  = '0;
      for (int i = 0; i < KEYMAP_SIZE; i++) begin
         if (r_held[i]) begin
            w_key_ctrl = w_key_ctrl | entry_ctrl_mask(i);
            w_key_svc  = w_key_svc | entry_svc_mask(i);
         end
      end
      w_raw = w_key_ctrl | r_joy;
   end

   // Autofire time-base controls; a period change restarts counting from 0
   always_comb begin
      w_vb_rise        = vblank & ~r_vblank_d;
      w_period_changed = (autofire_period != r_period_d);
      w_af_on          = (autofire_period != 8'd0);
      w_cnt_base       = r_af_restart ? 8'd0 : r_af_cnt;
   end

   // Vblank edge counter and autofire phase
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_vblank_d   <= 1'b0;
         r_period_d   <= 8'd0;
         r_af_cnt     <= 8'd0;
         r_af_phase   <= 1'b0;
         r_af_restart <= 1'b0;
      end else begin
         r_vblank_d <= vblank;
         r_period_d <= autofire_period;
         if (!w_af_on) begin
            r_af_cnt     <= 8'd0;
            r_af_phase   <= 1'b0;
            r_af_restart <= 1'b0;
         end else begin
            if (w_vb_rise) begin
               if (w_cnt_base >= autofire_period - 8'd1) begin
                  r_af_cnt   <= 8'd0;
                  r_af_phase <= ~r_af_phase;
               end else begin
                  r_af_cnt <= w_cnt_base + 8'd1;
               end
            end
            r_af_restart <= w_period_changed | (r_af_restart & ~w_vb_rise);
         end
      end
   end

   for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
      pulse_stretch #(
         .HOLD (COIN_HOLD)
      ) u_coin (
         .clock    (clock),
         .reset_n  (reset_n),
         .i_level  (w_raw[p*CTRL_W + COIN_BIT]),
         .o_active (w_coin_active[p])
      );
   end

   // Gate autofire-enabled buttons with the phase and stretch the coin bits
   always_comb begin
      w_next_ctrl = w_raw;
      for (int p = 0; p < PLAYERS; p++) begin
         for (int b = 0; b < BUTTONS; b++) begin
            if (w_af_on && autofire_mask[p*BUTTONS + b]) begin
               w_next_ctrl[p*CTRL_W + IDX_BTN0 + b] = w_raw[p*CTRL_W + IDX_BTN0 + b] & r_af_phase;
            end
         end
         w_next_ctrl[p*CTRL_W + COIN_BIT] = w_raw[p*CTRL_W + COIN_BIT] | w_coin_active[p];
      end
   end

   // Output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_controls <= '0;
         r_service  <= '0;
      end else begin
         r_controls <= w_next_ctrl;
         r_service  <= w_key_svc;
      end
   end

   assign controls = r_controls;
   assign service  = r_service;

endmodule

// File: tb/tb_input_mapper.sv
// tb/tb_input_mapper.sv - self-checking bench for input_mapper
module tb_input_mapper;

   localparam int P    = 4;
   localparam int B    = 6;
   localparam int HOLD = 5;
   localparam int CW   = B + 7;
   localparam int NC   = P * CW;
   localparam int NK   = 21;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [10:0]   ps2_key;
   logic          kbd_clear;
   logic [NC-1:0] joystick;
   logic          vblank;
   logic [P*B-1:0] autofire_mask;
   logic [7:0]    autofire_period;
   logic [NC-1:0] controls;
   logic [P-1:0]  service;

   input_mapper #(
      .PLAYERS   (P),
      .BUTTONS   (B),
      .COIN_HOLD (HOLD)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .ps2_key         (ps2_key),
      .kbd_clear       (kbd_clear),
      .joystick        (joystick),
      .vblank          (vblank),
      .autofire_mask   (autofire_mask),
      .autofire_period (autofire_period),
      .controls        (controls),
      .service         (service)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [7:0]    km_code [NK];
   logic          km_ext  [NK];
   int            km_player [NK];
   int            km_bit  [NK];
   logic [NK-1:0] held;
   logic [NC-1:0] joy_model;
   int            af_k;
   logic          af_phase;
   logic [63:0]   r64;
   logic [31:0]   r32;
   logic [15:0]   seq;
   logic [15:0]   expv;
   logic          b1_seen;
   int            sel, idx, cp, cd, cb;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic km_add(input int i, input logic [7:0] c, input logic e, input int pl, input int bpos);
      km_code[i]   = c;
      km_ext[i]    = e;
      km_player[i] = pl;
      km_bit[i]    = bpos;
   endtask

   task automatic kbd_event(input logic [7:0] code, input logic ext, input logic pr);
      ps2_key = {~ps2_key[10], pr, ext, code};
      for (int i = 0; i < NK; i++) begin
         if (km_code[i] == code && km_ext[i] == ext) held[i] = pr;
      end
   endtask

   function automatic logic [NC-1:0] exp_controls();
      logic [NC-1:0] v;
      v = joy_model;
      for (int i = 0; i < NK; i++) begin
         if (held[i] && km_bit[i] >= 0) v[km_player[i]*CW + km_bit[i]] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [P-1:0] exp_service();
      logic [P-1:0] s;
      s = '0;
      for (int i = 0; i < NK; i++) begin
         if (held[i] && km_bit[i] < 0) s[km_player[i]] = 1'b1;
      end
      return s;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      km_add(0,  8'h75, 1'b1, 0, 3);     km_add(1,  8'h72, 1'b1, 0, 2);
      km_add(2,  8'h6B, 1'b1, 0, 1);     km_add(3,  8'h74, 1'b1, 0, 0);
      km_add(4,  8'h14, 1'b0, 0, 4);     km_add(5,  8'h11, 1'b0, 0, 5);
      km_add(6,  8'h29, 1'b0, 0, 6);     km_add(7,  8'h16, 1'b0, 0, B+4);
      km_add(8,  8'h2E, 1'b0, 0, B+5);   km_add(9,  8'h4D, 1'b0, 0, B+6);
      km_add(10, 8'h46, 1'b0, 0, -1);    km_add(11, 8'h2D, 1'b0, 1, 3);
      km_add(12, 8'h2B, 1'b0, 1, 2);     km_add(13, 8'h23, 1'b0, 1, 1);
      km_add(14, 8'h34, 1'b0, 1, 0);     km_add(15, 8'h1C, 1'b0, 1, 4);
      km_add(16, 8'h1B, 1'b0, 1, 5);     km_add(17, 8'h15, 1'b0, 1, 6);
      km_add(18, 8'h1E, 1'b0, 1, B+4);   km_add(19, 8'h36, 1'b0, 1, B+5);
      km_add(20, 8'h45, 1'b0, 1, -1);
      held            = '0;
      joy_model       = '0;
      reset_n         = 1'b0;
      ps2_key         = {1'b1, 1'b1, 1'b1, 8'h75};
      kbd_clear       = 1'b0;
      joystick        = '0;
      vblank          = 1'b0;
      autofire_mask   = '0;
      autofire_period = 8'd0;

      // reset state, then toggle already high at release must not be an event
      tick(3);
      check("reset_controls", 64'(controls), 64'd0);
      check("reset_service", 64'(service), 64'd0);
      reset_n = 1'b1;
      tick(5);
      check("release_no_event_controls", 64'(controls), 64'd0);
      check("release_no_event_service", 64'(service), 64'd0);

      // extended 75 is P1 up with two-edge latency; plain 75 is unmapped
      kbd_event(8'h75, 1'b1, 1'b1);
      tick(1);
      check("up_edge1", 64'(controls[3]), 64'd0);
      tick(1);
      check("up_edge2", 64'(controls[3]), 64'd1);
      check("up_full", 64'(controls), 64'(exp_controls()));
      kbd_event(8'h75, 1'b0, 1'b0);
      tick(3);
      check("plain75_ignored", 64'(controls[3]), 64'd1);
      kbd_event(8'h75, 1'b1, 1'b0);
      tick(2);
      check("up_released", 64'(controls), 64'(exp_controls()));

      // clear beats a same-cycle event
      kbd_event(8'h2E, 1'b0, 1'b1);
      tick(3);
      check("coin_key_held", 64'(controls[B+5]), 64'd1);
      kbd_clear = 1'b1;
      ps2_key   = {~ps2_key[10], 1'b1, 1'b0, 8'h14};
      held      = '0;
      tick(1);
      kbd_clear = 1'b0;
      b1_seen   = controls[4];
      for (int i = 0; i < 8; i++) begin
         tick(1);
         b1_seen = b1_seen | controls[4];
      end
      check("clear_b1_never_set", 64'(b1_seen), 64'd0);
      check("clear_all_keys", 64'(controls), 64'd0);

      // randomized merge of keys and gamepads with autofire disabled
      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 3);
         if (sel == 0) begin
            r64       = {$urandom(), $urandom()};
            joy_model = r64[NC-1:0];
            joystick  = joy_model;
         end else if (sel == 3) begin
            kbd_event(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            idx = $urandom_range(0, NK-1);
            kbd_event(km_code[idx], km_ext[idx], 1'($urandom_range(0, 1)));
         end
         r32           = $urandom();
         autofire_mask = r32[P*B-1:0];
         tick(8);
         check("rand_controls", 64'(controls), 64'(exp_controls()));
         check("rand_service", 64'(service), 64'(exp_service()));
      end

      // every mapped key pressed: P3/P4 and buttons 4..6 still joystick-only
      for (int i = 0; i < NK; i++) begin
         kbd_event(km_code[i], km_ext[i], 1'b1);
         tick(1);
      end
      r64       = {$urandom(), $urandom()};
      joy_model = '0;
      joy_model[2*CW +: 2*CW] = r64[2*CW-1:0];
      joy_model[9:7]          = r64[63:61];
      joystick  = joy_model;
      tick(8);
      check("p34_joystick_only", 64'(controls[2*CW +: 2*CW]), 64'(joy_model[2*CW +: 2*CW]));
      check("btn4_6_joystick_only", 64'(controls[9:7]), 64'(joy_model[9:7]));
      check("all_keys_full", 64'(controls), 64'(exp_controls()));
      check("all_keys_service", 64'(service), 64'(exp_service()));
      kbd_clear = 1'b1;
      held      = '0;
      tick(1);
      kbd_clear = 1'b0;
      joy_model = '0;
      joystick  = '0;
      tick(8);

      // autofire on P1 button 1, button 2 held without autofire
      r32              = $urandom();
      autofire_mask    = r32[P*B-1:0];
      autofire_mask[0] = 1'b1;
      autofire_mask[1] = 1'b0;
      joy_model[4]     = 1'b1;
      joy_model[5]     = 1'b1;
      joystick         = joy_model;
      autofire_period  = 8'd2;
      af_k     = 0;
      af_phase = 1'b0;
      tick(3);
      check("af_start_phase", 64'(controls[4]), 64'd0);
      for (int rnd = 0; rnd < 2; rnd++) begin
         if (rnd == 1) begin
            autofire_period = 8'($urandom_range(1, 4));
            af_k = 0;
            tick(2);
         end
         for (int v = 0; v < 10; v++) begin
            vblank = 1'b1;
            tick(2);
            vblank = 1'b0;
            tick(2);
            af_k++;
            if (af_k == int'(autofire_period)) begin
               af_k     = 0;
               af_phase = ~af_phase;
            end
            check("af_btn1", 64'(controls[4]), 64'(af_phase));
            check("af_btn2_raw", 64'(controls[5]), 64'd1);
         end
      end
      autofire_period = 8'd0;
      tick(3);
      check("af_off_steady", 64'(controls[4]), 64'd1);
      vblank = 1'b1;
      tick(2);
      vblank = 1'b0;
      tick(2);
      check("af_off_after_vblank", 64'(controls[4]), 64'd1);
      joy_model = '0;
      joystick  = '0;
      tick(8);

      // coin stretch: single pulse, pulse at 3, random player and spacing
      for (int run = 0; run < 3; run++) begin
         cp = (run == 0 || run == 1) ? 0 : $urandom_range(0, P-1);
         cd = (run == 0) ? 99 : (run == 1) ? 3 : $urandom_range(2, 7);
         cb = cp*CW + B + 5;
         seq  = '0;
         expv = '0;
         for (int i = 0; i < 16; i++) begin
            joystick[cb] = (i == 0) || (i == cd);
            @(posedge clock);
            @(negedge clock);
            seq[i] = controls[cb];
            if (i >= 1 && i <= HOLD) expv[i] = 1'b1;
            if (cd < 16 && i >= cd + 1 && i <= cd + HOLD) expv[i] = 1'b1;
         end
         joystick[cb] = 1'b0;
         check("coin_shape", 64'(seq), 64'(expv));
         if (run == 0) check("coin_single_len", 64'($countones(seq)), 64'(HOLD));
         tick(10);
      end

      // reset mid-stretch aborts; toggle seen during reset is not an event
      cb = B + 5;
      joystick[cb] = 1'b1;
      tick(1);
      joystick[cb] = 1'b0;
      tick(1);
      check("coin_before_reset", 64'(controls[cb]), 64'd1);
      #2;
      reset_n = 1'b0;
      ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h14};
      held    = '0;
      #1;
      check("async_reset_controls", 64'(controls), 64'd0);
      check("async_reset_service", 64'(service), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      tick(6);
      check("post_reset_quiet", 64'(controls), 64'd0);
      kbd_event(8'h14, 1'b0, 1'b1);
      tick(2);
      check("post_reset_event", 64'(controls), 64'(exp_controls()));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
